adder_subtractor_bist: RTL and testbench

Hardware stimulus-and-check controller for the 4-bit adder/subtractor datapath. It sits on the opposite side of the adder/subtractor interface. It drives A, B and sel exhaustively, samples S and cout after a settle interval, and compares them against an internal golden model. It reports pass/fail, an error count and the first failing vector, so the lab board can self-test the unit without a simulator.

---
 rtl/adder_subtractor_bist.sv | 128 ++++++++++++
 tb/tb_adder_subtractor_bist.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/adder_subtractor_bist.sv
// Exhaustive stimulus/check controller for a WIDTH-bit adder/subtractor: sweeps {sel,B,A}, compares {cout,S} to a golden model.
// Each vector costs SETTLE_CYCLES+2 cycles; start is ignored while a sweep is running.
module adder_subtractor_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [WIDTH-1:0]     A,
  output logic [WIDTH-1:0]     B,
  output logic                 sel,
  input  logic [WIDTH-1:0]     S,
  input  logic                 cout,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH+1:0]   vec_count,
  output logic                 fail_valid,
  output logic [2*WIDTH:0]     fail_vec,
  output logic [WIDTH:0]       fail_resp
);

  localparam int VW = 2*WIDTH+1;
  localparam int CW = 2*WIDTH+2;
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES+1) : 1;

  typedef enum logic [2:0] {IDLE, APPLY, WAIT, CHECK, DONE} state_t;

  state_t          state, state_nxt;
  logic [VW-1:0]   v;
  logic [SW-1:0]   settle;
  logic [WIDTH:0]  expected;
  logic [WIDTH:0]  observed;
  logic            mismatch;
  logic            last_vec;
  logic            stop_now;

  // Subtraction is A + ~B + 1, so cout doubles as "no borrow" (A >= B).
  always_comb begin
    expected = {1'b0, A} + {1'b0, (sel ? ~B : B)} + {{WIDTH{1'b0}}, sel};
    observed = {cout, S};
    mismatch = (observed != expected);
    last_vec = &v;
    stop_now = last_vec || ((STOP_ON_FAIL != 0) && mismatch);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = APPLY;
      APPLY: begin
        busy      = 1'b1;
        state_nxt = (SETTLE_CYCLES > 0) ? WAIT : CHECK;
      end
      WAIT: begin
        busy = 1'b1;
        if (settle == SW'(1)) state_nxt = CHECK;
      end
      CHECK: begin
        busy      = 1'b1;
        state_nxt = stop_now ? DONE : APPLY;
      end
      DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) state_nxt = APPLY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      v          <= '0;
      settle     <= '0;
      A          <= '0;
      B          <= '0;
      sel        <= 1'b0;
      err_count  <= '0;
      vec_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
      fail_resp  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            v          <= '0;
            err_count  <= '0;
            vec_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_resp  <= '0;
          end
        end
        APPLY: begin
          A      <= v[WIDTH-1:0];
          B      <= v[2*WIDTH-1:WIDTH];
          sel    <= v[2*WIDTH];
          settle <= SW'(SETTLE_CYCLES);
        end
        WAIT: settle <= settle - SW'(1);
        CHECK: begin
          vec_count <= vec_count + CW'(1);
          if (mismatch) begin
            err_count <= err_count + CW'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= {sel, B, A};
              fail_resp  <= observed;
            end
          end
          if (!last_vec) v <= v + VW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_subtractor_bist.sv
// Directed bench: three controllers (default, stop-on-fail, zero settle) each driving a behavioural unit with selectable faults.
module tb_adder_subtractor_bist;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]         start_v = '0;
  logic [2:0][3:0]    a_v, b_v, s_v;
  logic [2:0]         sel_v, cout_v, busy_v, done_v, pass_v, fv_v;
  logic [2:0][9:0]    err_v, vec_v;
  logic [2:0][8:0]    fvec_v;
  logic [2:0][4:0]    fresp_v;
  logic [1:0]         mode [3];

  int checks = 0;
  int errors = 0;

  // Reference arithmetic: subtract as A + 16 - B so bit 4 is the no-borrow flag.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic s);
    if (s) return 5'(a) + 5'd16 - 5'(b);
    else   return 5'(a) + 5'(b);
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_dut
    logic [4:0] gold, regd, resp;
    always_ff @(posedge clk) regd <= model(a_v[i], b_v[i], sel_v[i]);
    always_comb begin
      gold = model(a_v[i], b_v[i], sel_v[i]);
      case (mode[i])
        2'd1:    resp = gold & 5'b11110;
        2'd2:    resp = gold & 5'b01111;
        2'd3:    resp = regd;
        default: resp = gold;
      endcase
    end
    assign s_v[i]    = resp[3:0];
    assign cout_v[i] = resp[4];

    adder_subtractor_bist #(
      .WIDTH(4),
      .SETTLE_CYCLES((i == 2) ? 0 : 2),
      .STOP_ON_FAIL((i == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[i]),
      .A(a_v[i]), .B(b_v[i]), .sel(sel_v[i]),
      .S(s_v[i]), .cout(cout_v[i]),
      .busy(busy_v[i]), .done(done_v[i]), .pass(pass_v[i]),
      .err_count(err_v[i]), .vec_count(vec_v[i]),
      .fail_valid(fv_v[i]), .fail_vec(fvec_v[i]), .fail_resp(fresp_v[i])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start, optionally pulses it again mid-sweep, returns cycles from the sampling edge to done.
  task automatic run_sweep(input int idx, input bit mid_pulse, output int cycles);
    @(negedge clk);
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    cycles = 0;
    while (!done_v[idx] && cycles < 5000) begin
      @(posedge clk); #1;
      cycles++;
      if (mid_pulse && cycles == 500) start_v[idx] = 1'b1;
      if (mid_pulse && cycles == 501) start_v[idx] = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int n;
    mode[0] = 2'd0; mode[1] = 2'd1; mode[2] = 2'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_abs", {28'd0, a_v[0]} | {28'd0, b_v[0]} | {31'd0, sel_v[0]}, 0);
    check("rst_flags", {29'd0, busy_v[0], done_v[0], pass_v[0]}, 0);
    check("rst_counts", {12'd0, err_v[0], vec_v[0]}, 0);
    check("rst_fail", {17'd0, fv_v[0], fvec_v[0], fresp_v[0]}, 0);
    @(negedge clk) rst_n = 1'b1;

    // Healthy unit, default settle
    run_sweep(0, 1'b0, cyc);
    check("gold_cycles", cyc, 2048);
    check("gold_vec", vec_v[0], 512);
    check("gold_err", err_v[0], 0);
    check("gold_pass", pass_v[0], 1);
    check("gold_fv", fv_v[0], 0);
    check("gold_busy", busy_v[0], 0);
    check("gold_ab_hold", {a_v[0], b_v[0], sel_v[0]}, {4'hF, 4'hF, 1'b1});

    // S[0] stuck-at-0
    mode[0] = 2'd1;
    run_sweep(0, 1'b0, cyc);
    check("s0_err", err_v[0], 256);
    check("s0_pass", pass_v[0], 0);
    check("s0_fv", fv_v[0], 1);
    check("s0_fvec", fvec_v[0], 9'h001);
    check("s0_fresp", fresp_v[0], 5'h00);

    // cout stuck-at-0: first failure is A=15,B=1 add
    mode[0] = 2'd2;
    run_sweep(0, 1'b0, cyc);
    check("co_err", err_v[0], 256);
    check("co_vec", vec_v[0], 512);
    check("co_fvec", fvec_v[0], {1'b0, 4'd1, 4'd15});
    check("co_fresp", fresp_v[0], 5'h00);

    // Stop-on-fail with S[0] stuck
    run_sweep(1, 1'b0, cyc);
    check("sof_cycles", cyc, 8);
    check("sof_vec", vec_v[1], 2);
    check("sof_err", err_v[1], 1);
    check("sof_pass", pass_v[1], 0);
    check("sof_abs", {a_v[1], b_v[1], sel_v[1]}, {4'd1, 4'd0, 1'b0});

    // Reset mid-sweep at vector 100
    mode[0] = 2'd0;
    @(negedge clk) start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    n = 0;
    while (vec_v[0] != 10'd100 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_v100", vec_v[0], 100);
    check("mid_busy", busy_v[0], 1);
    rst_n = 1'b0;
    #1;
    check("arst_abs", {a_v[0], b_v[0], sel_v[0]}, 0);
    check("arst_flags", {busy_v[0], done_v[0], pass_v[0]}, 0);
    check("arst_counts", {err_v[0], vec_v[0]}, 0);
    check("arst_fail", {fv_v[0], fvec_v[0], fresp_v[0]}, 0);
    @(negedge clk) rst_n = 1'b1;

    run_sweep(0, 1'b1, cyc);
    check("post_rst_cycles", cyc, 2048);
    check("post_rst_vec", vec_v[0], 512);
    check("post_rst_pass", pass_v[0], 1);

    // Zero settle: golden passes, registered unit fails
    run_sweep(2, 1'b0, cyc);
    check("z_cycles", cyc, 1024);
    check("z_pass", pass_v[2], 1);
    mode[2] = 2'd3;
    run_sweep(2, 1'b0, cyc);
    check("z_reg_pass", pass_v[2], 0);

    // Registered unit is fine with two settle cycles
    mode[0] = 2'd3;
    run_sweep(0, 1'b0, cyc);
    check("s2_reg_pass", pass_v[0], 1);
    check("s2_reg_err", err_v[0], 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
